// File: rtl/imem_loader.sv
// imem_loader: packs a UART byte stream into big-endian 32-bit words and
// writes them to instruction memory at sequential word-aligned addresses,
// stopping on a halt word or when the last memory slot has been written.
module imem_loader #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  RxData,
   input  logic        RxValid,
   output logic        WrEn,
   output logic [31:0] WrAddr,
   output logic [31:0] WrData,
   output logic [31:0] WordCount,
   output logic        Busy,
   output logic        Done,
   output logic        Overflow
);

   // Byte address of the final memory slot; a non-halt word written here ends the load.
   localparam logic [31:0] LAST_ADDR = 32'((DEPTH_WORDS - 1) * 4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;     // bytes already packed into the current word
   logic [31:0] asm_q, asm_d;     // word assembly shift register
   logic [31:0] addr_q, addr_d;   // byte address of the next write
   logic [31:0] count_q, count_d; // words written since Start
   logic        pend_q, pend_d;   // completed word waiting for its write cycle

   // State and datapath registers, cleared asynchronously by Reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         asm_q   <= 32'd0;
         addr_q  <= 32'd0;
         count_q <= 32'd0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state logic: Start restarts everything; otherwise retire a pending
   // write and pack any byte received while loading.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      addr_d  = addr_q;
      count_d = count_q;
      pend_d  = pend_q;

      if (Start) begin
         // Start beats a coincident RxValid: the byte is dropped.
         state_d = S_LOAD;
         idx_d   = 2'd0;
         asm_d   = 32'd0;
         addr_d  = 32'd0;
         count_d = 32'd0;
         pend_d  = 1'b0;
      end else begin
         if (pend_q) begin
            // Write cycle: advance the address/count and judge the written word.
            pend_d  = 1'b0;
            addr_d  = addr_q + 32'd4;
            count_d = count_q + 32'd1;
            if (asm_q == HALT_WORD) begin
               state_d = S_DONE;
            end else if (addr_q == LAST_ADDR) begin
               state_d = S_ERROR;
            end else begin
               state_d = state_q;
            end
         end else begin
            pend_d = 1'b0;
         end

         // A byte in the write cycle starts the next word; asm_q still holds
         // the completed word for WrData until this edge.
         if ((state_q == S_LOAD) && RxValid) begin
            asm_d = {asm_q[23:0], RxData};
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               pend_d = 1'b1;
            end else begin
               pend_d = pend_d;
            end
         end else begin
            asm_d = asm_q;
         end
      end
   end

   // Outputs come straight from registers so they are glitch-free.
   assign WrEn      = pend_q;
   assign WrAddr    = addr_q;
   assign WrData    = asm_q;
   assign WordCount = count_q;
   assign Busy      = (state_q == S_LOAD);
   assign Done      = (state_q == S_DONE);
   assign Overflow  = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a small memory (4 words) so the
// overflow path is reachable; expected writes come from a word-level model.
module tb_imem_loader;

   localparam int          TB_DEPTH = 4;
   localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [7:0]  RxData;
   logic        RxValid;
   logic        WrEn;
   logic [31:0] WrAddr;
   logic [31:0] WrData;
   logic [31:0] WordCount;
   logic        Busy;
   logic        Done;
   logic        Overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0]  stim[$];
   logic [31:0] cap_addr[$];
   logic [31:0] cap_data[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic        exp_done;
   logic        exp_ovf;

   imem_loader #(.DEPTH_WORDS(TB_DEPTH), .HALT_WORD(HALT)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .RxData(RxData),
      .RxValid(RxValid), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
      .WordCount(WordCount), .Busy(Busy), .Done(Done), .Overflow(Overflow)
   );

   always #5 Clock = ~Clock;

   // Record every write strobe seen mid-cycle.
   always @(negedge Clock) begin
      if (WrEn === 1'b1) begin
         cap_addr.push_back(WrAddr);
         cap_data.push_back(WrData);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycle();
      @(negedge Clock);
      RxValid = 1'b0;
      @(posedge Clock);
      #1;
   endtask

   task automatic drive_byte(input logic [7:0] b);
      @(negedge Clock);
      RxValid = 1'b1;
      RxData  = b;
      @(posedge Clock);
      #1;
      RxValid = 1'b0;
   endtask

   task automatic start_pulse();
      cap_addr.delete();
      cap_data.delete();
      stim.delete();
      @(negedge Clock);
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      check("busy_after_start", {31'd0, Busy}, 32'd1);
   endtask

   task automatic start_with_byte(input logic [7:0] b);
      cap_addr.delete();
      cap_data.delete();
      stim.delete();
      @(negedge Clock);
      Start   = 1'b1;
      RxValid = 1'b1;
      RxData  = b;
      @(posedge Clock);
      #1;
      Start   = 1'b0;
      RxValid = 1'b0;
   endtask

   task automatic drive_stim(input int gap_max);
      foreach (stim[k]) begin
         int gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         for (int g = 0; g < gaps; g++) idle_cycle();
         drive_byte(stim[k]);
      end
   endtask

   // Reference: cut the accepted bytes into big-endian words and walk memory
   // from address 0 until a halt word or the last slot has been written.
   task automatic model_expect();
      int nw;
      logic [31:0] w;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 1'b0;
      exp_ovf  = 1'b0;
      nw = stim.size() / 4;
      for (int i = 0; i < nw; i++) begin
         w = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
         exp_addr.push_back(32'(i * 4));
         exp_data.push_back(w);
         if (w == HALT) begin
            exp_done = 1'b1;
            break;
         end
         if (i == TB_DEPTH - 1) begin
            exp_ovf = 1'b1;
            break;
         end
      end
   endtask

   task automatic settle_and_compare(input string tag);
      int n;
      for (int c = 0; c < 4; c++) idle_cycle();
      model_expect();
      check({tag, "_nwrites"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
      n = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_addr"}, cap_addr[i], exp_addr[i]);
         check({tag, "_data"}, cap_data[i], exp_data[i]);
      end
      check({tag, "_done"}, {31'd0, Done}, {31'd0, exp_done});
      check({tag, "_ovf"}, {31'd0, Overflow}, {31'd0, exp_ovf});
      check({tag, "_busy"}, {31'd0, Busy}, {31'd0, ~(exp_done | exp_ovf)});
      check({tag, "_count"}, WordCount, 32'(exp_addr.size()));
   endtask

   initial begin
      logic [31:0] w;
      int nw;
      Reset   = 1'b1;
      Start   = 1'b0;
      RxValid = 1'b0;
      RxData  = 8'd0;

      // Reset values
      #12;
      check("rst_wren", {31'd0, WrEn}, 32'd0);
      check("rst_addr", WrAddr, 32'd0);
      check("rst_data", WrData, 32'd0);
      check("rst_count", WordCount, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_ovf", {31'd0, Overflow}, 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      // Bytes in IDLE are ignored
      drive_byte(8'h11);
      drive_byte(8'h22);
      drive_byte(8'h33);
      drive_byte(8'h44);
      for (int c = 0; c < 3; c++) idle_cycle();
      check("idle_nwrites", 32'(cap_addr.size()), 32'd0);
      check("idle_count", WordCount, 32'd0);
      check("idle_busy", {31'd0, Busy}, 32'd0);

      // Basic program ending on a halt word, with write/Done timing checks
      start_pulse();
      stim = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
      drive_stim(0);
      @(negedge Clock);
      check("lat_wren", {31'd0, WrEn}, 32'd1);
      check("lat_wrdata", WrData, 32'hFFFF_FFFF);
      check("lat_wraddr", WrAddr, 32'd8);
      check("lat_done_early", {31'd0, Done}, 32'd0);
      @(negedge Clock);
      check("lat_done", {31'd0, Done}, 32'd1);
      check("lat_busy", {31'd0, Busy}, 32'd0);
      check("lat_wren_once", {31'd0, WrEn}, 32'd0);
      settle_and_compare("prog");

      // Eight non-halt words overflow a four-word memory
      start_pulse();
      for (int i = 0; i < 32; i++) stim.push_back(8'(i + 1));
      drive_stim(0);
      settle_and_compare("ovf");

      // Halt in the final slot counts as Done, not Overflow
      start_pulse();
      for (int i = 0; i < 12; i++) stim.push_back(8'(8'h30 + 8'(i)));
      for (int i = 0; i < 4; i++) stim.push_back(8'hFF);
      drive_stim(0);
      settle_and_compare("halt_last");

      // Restart mid-word, with Start coinciding with a byte
      start_pulse();
      drive_byte(8'hAA);
      drive_byte(8'hBB);
      start_with_byte(8'hCC);
      stim = '{8'hDD, 8'hEE, 8'hFF, 8'h01};
      drive_stim(0);
      settle_and_compare("restart");

      // Asynchronous reset mid-word
      start_pulse();
      drive_byte(8'h5A);
      drive_byte(8'hA5);
      @(negedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("arst_busy", {31'd0, Busy}, 32'd0);
      check("arst_data", WrData, 32'd0);
      check("arst_addr", WrAddr, 32'd0);
      check("arst_count", WordCount, 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      start_pulse();
      stim = '{8'h12, 8'h34, 8'h56, 8'h78};
      drive_stim(0);
      settle_and_compare("after_rst");

      // Randomized programs with idle gaps and trailing partial words
      for (int it = 0; it < 25; it++) begin
         start_pulse();
         nw = int'($urandom_range(1, 6));
         for (int i = 0; i < nw; i++) begin
            w = ($urandom_range(0, 5) == 0) ? HALT : 32'($urandom);
            stim.push_back(w[31:24]);
            stim.push_back(w[23:16]);
            stim.push_back(w[15:8]);
            stim.push_back(w[7:0]);
         end
         for (int p = int'($urandom_range(0, 3)); p > 0; p--) stim.push_back(8'($urandom));
         drive_stim(2);
         settle_and_compare("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writes program words into instruction memory ahead of execution. The PC reads instruction memory one word per fetch; this block fills that memory before the core is enabled. It takes a byte stream from the debug UART receiver and packs each group of four bytes into a big-endian 32-bit word. It writes the words to sequential word-aligned byte addresses starting at 0, and stops on a halt word or on memory overflow.

## Interface
- DEPTH_WORDS, 256: instruction memory capacity in 32-bit words.
- HALT_WORD, 32'hFFFFFFFF: end-of-program marker. It is written to memory, then loading terminates.
- Clock  input  1: rising-edge clock.
- Reset  input  1: asynchronous, active-high.
- Start  input  1: one-cycle pulse. Begins or restarts a load.
- RxData  input  8: received byte.
- RxValid  input  1: RxData valid this cycle. One byte per asserted cycle; may be asserted back-to-back.
- WrEn  output  1: one-cycle instruction memory write strobe.
- WrAddr  output  32: byte address of the write. Always a multiple of 4.
- WrData  output  32: word to write.
- WordCount  output  32: words written since the last Start.
- Busy  output  1: high in LOAD.
- Done  output  1: high in DONE (level).
- Overflow  output  1: high in ERROR (level).

## Operation
- States:
  - IDLE: after reset.
  - LOAD
  - DONE
  - ERROR
- Registers:
  - 2-bit byte index.
  - 32-bit assembly register.
  - Write address.
  - WordCount.
  - Pending-write flag.
- Start in any state:
  - Go to LOAD.
  - Clear byte index, assembly register, WrAddr and WordCount.
  - Cancel any pending write.
- In LOAD, each RxValid byte shifts into the assembly register: asm <= {asm[23:0], RxData}. The first byte received ends up in bits 31:24.
- The byte index increments modulo 4 on each byte.
- When the byte index is 3, the word completes:
  - Set the pending flag; the write happens on the next cycle.
  - Byte index returns to 0.
- Write cycle:
  - WrEn=1.
  - WrData = completed word.
  - WrAddr = current address.
  - On the following edge: WrAddr += 4 and WordCount += 1.
- End conditions, evaluated on the written word:
  - Word == HALT_WORD: go to DONE. Halt takes priority over overflow.
  - Otherwise, if it was written to the last slot (address (DEPTH_WORDS-1)*4): go to ERROR.
  - Otherwise: stay in LOAD.
- RxValid is ignored in IDLE, DONE and ERROR.
- Start together with RxValid in the same cycle: Start wins and the byte is dropped.
- A byte arriving during the write cycle is accepted normally as the first byte of the next word.
- Partial word (1–3 bytes) when Start re-arrives: discarded, nothing written.
- WrAddr never exceeds (DEPTH_WORDS-1)*4 while WrEn=1. No wrap-around.
- Reset mid-operation:
  - Immediate return to IDLE.
  - Partial word and pending write lost.
  - Memory contents are not touched.

## Timing
- Reset values:
  - State IDLE.
  - WrEn=0.
  - WrAddr=0.
  - WrData=0.
  - WordCount=0.
  - Busy=0, Done=0, Overflow=0.
- Busy rises the cycle after Start.
- Latency: the 4th byte is sampled on edge N; WrEn is high in cycle N+1.
- After the halt word: Done rises on the edge ending the write cycle, i.e. Done is high from cycle N+2, and Busy falls at the same time.
- Overflow follows the same timing as Done.
- WrEn is high for exactly one cycle per word, and WrData/WrAddr are stable during it.
- Maximum throughput: one word per 4 cycles with continuous RxValid.
- WordCount and WrAddr update on the edge after WrEn.

## Test plan
- Reset then idle: all outputs 0. RxValid with bytes 0x11..0x44 in IDLE → no WrEn, WordCount=0.
- Start, then bytes 20 01 00 05, 00 00 00 00, FF FF FF FF:
  - Three WrEn pulses: 0x20010005@0, 0x00000000@4, 0xFFFFFFFF@8.
  - Done=1, WordCount=3, Busy=0.
- DEPTH_WORDS=4, eight non-halt words:
  - Four writes at 0, 4, 8, 12, then Overflow=1.
  - Remaining bytes produce no WrEn; WordCount=4.
- Halt word in the last slot (DEPTH_WORDS=4, halt as 4th word) → Done=1, Overflow=0.
- Bytes AA BB, then Start coinciding with RxValid byte CC, then DD EE FF 01 → a single write 0xDDEEFF01@0. The partial word and CC are discarded.
- Reset asserted mid-word after 2 bytes → outputs return to reset values immediately. A subsequent Start plus full word writes @0.
